// File: rtl/shift_sub_divider.sv
// shift_sub_divider: unsigned restoring shift-subtract divider.
// A normal division takes 2N cycles (one SH and one SUB step per quotient bit).
// Optional feature macro: DIV_ZERO_DETECT_EN. When it is defined, a zero divisor
// skips the loop and reports V=1. When it is not defined, V is tied low and a
// zero divisor runs the normal loop.
module shift_sub_divider #(
  parameter int N = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         St,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         Idle,
  output logic         Done,
  output logic         V
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SH, SUB, DONE} state_t;

  state_t         state, nstate;
  logic [N:0]     acc;
  logic [N-1:0]   quo;
  logic [N-1:0]   dvs;
  logic [CW-1:0]  cnt;

  logic           ge;
  logic [N:0]     accsub;
  logic [N-1:0]   quosub;
  logic           last;
  logic           zerostart;

  // Trial subtraction for the current SUB step, plus the last-iteration and
  // zero-divisor fast-path decodes.
  always_comb begin
    ge     = (acc >= {1'b0, dvs});
    accsub = ge ? (acc - {1'b0, dvs}) : acc;
    quosub = {quo[N-1:1], ge};
    last   = (cnt == CW'(N - 1));
`ifdef DIV_ZERO_DETECT_EN
    zerostart = (Divisor == '0);
`else
    zerostart = 1'b0;
`endif
  end

  // State register; reset always returns to IDLE.
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state and status decode. St is only looked at in IDLE.
  always_comb begin
    nstate = state;
    Idle   = 1'b0;
    Done   = 1'b0;
    case (state)
      IDLE: begin
        Idle = 1'b1;
        if (St) nstate = zerostart ? DONE : SH;
      end
      SH:   nstate = SUB;
      SUB:  nstate = last ? DONE : SH;
      DONE: begin
        Done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Datapath: operand capture, shift, conditional subtract. The result
  // registers load only on the transition into DONE.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc       <= '0;
      quo       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (St) begin
            acc <= '0;
            quo <= Dividend;
            dvs <= Divisor;
            cnt <= '0;
            if (zerostart) begin
              Quotient  <= '1;
              Remainder <= Dividend;
            end
          end
        end
        SH: begin
          {acc, quo} <= {acc[N-1:0], quo, 1'b0};
        end
        SUB: begin
          acc <= accsub;
          quo <= quosub;
          cnt <= cnt + CW'(1);
          if (last) begin
            Quotient  <= quosub;
            Remainder <= accsub[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic vflag;

  // The divide-by-zero flag is set or cleared at each start and holds until
  // the next start.
  always_ff @(posedge Clk) begin
    if (Rst)                    vflag <= 1'b0;
    else if (state == IDLE && St) vflag <= zerostart;
  end

  assign V = vflag;
`else
  assign V = 1'b0;
`endif

endmodule

// File: doc/shift_sub_divider.md
SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand/result width in bits (N >= 2).
REQ-002 SHALL have port Clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port Rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port St  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port Dividend  input  N  unsigned dividend, captured at start.
REQ-006 SHALL have port Divisor  input  N  unsigned divisor, captured at start.
REQ-007 SHALL have port Quotient  output  N  registered quotient.
REQ-008 SHALL have port Remainder  output  N  registered remainder.
REQ-009 SHALL have port Idle  output  1  high while in IDLE.
REQ-010 SHALL have port Done  output  1  one-cycle completion strobe.
REQ-011 SHALL have port V  output  1  divide-by-zero flag, valid while Done is high and held until next start.

Function
REQ-012 SHALL implement unsigned restoring shift-subtract division (the inverse of the team's shift-add multiplier).
REQ-013 SHALL use FSM states IDLE, SH, SUB, DONE.
REQ-014 IDLE: St=1 SHALL load A(N+1 bits)=0, Q=Dividend, D=Divisor, iteration counter=0, then go to SH. St=0 SHALL stay in IDLE.
REQ-015 SH: SHALL shift {A,Q} left one bit with 0 into Q[0], then go to SUB.
REQ-016 SUB: if A >= {0,D}, SHALL set A = A - D and Q[0] = 1, else leave A and Q unchanged. SHALL increment counter. SHALL go to DONE when counter reaches N-1, else go to SH.
REQ-017 DONE: SHALL assert Done for exactly one cycle, then go to IDLE unconditionally.
REQ-018 Quotient/Remainder SHALL update only on entry to DONE (Quotient=Q, Remainder=A[N-1:0]). SHALL hold until the next DONE entry or reset.
REQ-019 Normal latency: Done SHALL be high in the cycle starting 2N rising edges after the edge that sampled St=1 (16 for N=8).
REQ-020 Start handshake: St SHALL be ignored in SH, SUB and DONE. Operand changes after the load edge SHALL have no effect.
REQ-021 Back-to-back: St held high SHALL restart in the cycle after DONE (IDLE lasts one cycle).
REQ-022 Idle SHALL be high only in IDLE. Done SHALL be high only in DONE. Both SHALL never be high together.
REQ-023 Arithmetic SHALL be exact for all operand pairs with Divisor != 0: Dividend = Quotient*Divisor + Remainder, and Remainder < Divisor.

Reset
REQ-024 Rst=1 at a rising edge SHALL force IDLE and clear Quotient, Remainder, V, A, Q, D and the counter to 0, regardless of current state.
REQ-025 After reset: Idle=1, Done=0. Rst SHALL take priority over St on the same edge.
REQ-026 Reset mid-operation SHALL abort the division without producing a Done pulse.

Configuration
REQ-027 Macro DIV_ZERO_DETECT_EN SHALL enable divide-by-zero fast path.
REQ-028 With DIV_ZERO_DETECT_EN defined:
- Divisor=0 at the load edge SHALL go IDLE->DONE directly.
- SHALL set Quotient = all ones, Remainder = Dividend, V=1.
- Done SHALL be high in the cycle after the start edge.
- V SHALL be 0 for every nonzero divisor.
REQ-029 Without DIV_ZERO_DETECT_EN:
- V SHALL be tied to 0.
- Divisor=0 SHALL run the normal 2N-cycle algorithm, yielding Quotient = all ones and Remainder = Dividend.

Verification
REQ-030 N=8, Dividend=100, Divisor=7, St pulse -> Done 16 edges later, Quotient=14, Remainder=2, V=0.
REQ-031 N=8, 255/1 then 5/9 back-to-back with St held high -> Quotient=255, Remainder=0; then Quotient=0, Remainder=5; one Idle cycle between the two Done pulses.
REQ-032 N=8, 37/0 with DIV_ZERO_DETECT_EN -> Done 1 edge after start, Quotient=0xFF, Remainder=37, V=1. Without the macro -> Done after 16 edges, same Quotient/Remainder, V=0.
REQ-033 Start 200/3, assert Rst during 3rd SUB -> next cycle Idle=1, Quotient=Remainder=0, no Done pulse. New start 200/3 -> Quotient=66, Remainder=2.
REQ-034 Start 50/5, toggle St and change Dividend/Divisor during SH/SUB -> result still Quotient=10, Remainder=0, exactly one Done pulse.
